// File: rtl/hsst_rst_pkg.sv
// Shared state encoding and default cycle counts for the HSST reset sequencer.
// Pure declarations; no logic, no latency, no flow control.
package hsst_rst_pkg;

    typedef enum logic [2:0] {
        S_PLL_RST  = 3'd0,
        S_PLL_WAIT = 3'd1,
        S_LANE_RST = 3'd2,
        S_CDR_WAIT = 3'd3,
        S_RX_RST   = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    localparam int DEF_PLL_RST_CYC     = 64;
    localparam int DEF_LANE_RST_CYC    = 32;
    localparam int DEF_RX_RST_CYC      = 16;
    localparam int DEF_LOCK_STABLE_CYC = 128;
    localparam int DEF_CNT_WIDTH       = 10;

endpackage

// File: rtl/hsst_lock_debounce.sv
// 2-FF synchronizer plus saturating stable counter for one async lock input.
// Latency: lock_sync 2 cycles, lock_stable 2+STABLE_CYC cycles; no backpressure.
module hsst_lock_debounce #(
    parameter int STABLE_CYC = 128,
    parameter int CNT_WIDTH  = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic lock_async,
    output logic lock_sync,
    output logic lock_stable
);

    localparam logic [CNT_WIDTH-1:0] SAT = CNT_WIDTH'(STABLE_CYC);

    logic                 lock_meta;
    logic [CNT_WIDTH-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_meta <= 1'b0;
            lock_sync <= 1'b0;
            cnt       <= '0;
        end else begin
            lock_meta <= lock_async;
            lock_sync <= lock_meta;
            // any synchronized low restarts the stability window
            if (!lock_sync) begin
                cnt <= '0;
            end else if (cnt != SAT) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign lock_stable = (cnt == SAT);

endmodule

// File: rtl/hsst_rst_seq_v1_0.sv
// HSST PLL/lane/RX reset sequencer with debounced lock waits and watchdog hooks.
// Outputs registered, change with the state register; no backpressure.
module hsst_rst_seq_v1_0
    import hsst_rst_pkg::*;
#(
    parameter int PLL_RST_CYC     = DEF_PLL_RST_CYC,
    parameter int LANE_RST_CYC    = DEF_LANE_RST_CYC,
    parameter int RX_RST_CYC      = DEF_RX_RST_CYC,
    parameter int LOCK_STABLE_CYC = DEF_LOCK_STABLE_CYC,
    parameter int CNT_WIDTH       = DEF_CNT_WIDTH
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pll_lock_async,
    input  logic cdr_lock_async,
    input  logic wtchdg_rst_n,
    output logic pll_rst,
    output logic lane_rst,
    output logic rx_rst,
    output logic seq_done,
    output logic wtchdg_in,
    output logic wtchdg_clr
);

    localparam logic [CNT_WIDTH-1:0] PLL_LAST  = CNT_WIDTH'(PLL_RST_CYC - 1);
    localparam logic [CNT_WIDTH-1:0] LANE_LAST = CNT_WIDTH'(LANE_RST_CYC - 1);
    localparam logic [CNT_WIDTH-1:0] RX_LAST   = CNT_WIDTH'(RX_RST_CYC - 1);

    state_t               state;
    state_t               state_nxt;
    logic [CNT_WIDTH-1:0] timer;
    logic                 pll_sync;
    logic                 pll_stable;
    logic                 cdr_sync;
    logic                 cdr_stable;

    hsst_lock_debounce #(
        .STABLE_CYC (LOCK_STABLE_CYC),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_pll_db (
        .clk         (clk),
        .rst_n       (rst_n),
        .lock_async  (pll_lock_async),
        .lock_sync   (pll_sync),
        .lock_stable (pll_stable)
    );

    hsst_lock_debounce #(
        .STABLE_CYC (LOCK_STABLE_CYC),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_cdr_db (
        .clk         (clk),
        .rst_n       (rst_n),
        .lock_async  (cdr_lock_async),
        .lock_sync   (cdr_sync),
        .lock_stable (cdr_stable)
    );

    // lock loss keys off the synchronized bit so a drop acts two cycles after it happens
    always_comb begin
        state_nxt = state;
        if (!wtchdg_rst_n) begin
            state_nxt = S_PLL_RST;
        end else if (!pll_sync && (state inside {S_LANE_RST, S_CDR_WAIT, S_RX_RST, S_DONE})) begin
            state_nxt = S_PLL_RST;
        end else if (!cdr_sync && (state inside {S_RX_RST, S_DONE})) begin
            state_nxt = S_CDR_WAIT;
        end else begin
            case (state)
                S_PLL_RST:  if (timer == PLL_LAST)  state_nxt = S_PLL_WAIT;
                S_PLL_WAIT: if (pll_stable)         state_nxt = S_LANE_RST;
                S_LANE_RST: if (timer == LANE_LAST) state_nxt = S_CDR_WAIT;
                S_CDR_WAIT: if (cdr_stable)         state_nxt = S_RX_RST;
                S_RX_RST:   if (timer == RX_LAST)   state_nxt = S_DONE;
                S_DONE:     state_nxt = S_DONE;
                default:    state_nxt = S_PLL_RST;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_PLL_RST;
            timer      <= '0;
            pll_rst    <= 1'b1;
            lane_rst   <= 1'b1;
            rx_rst     <= 1'b1;
            seq_done   <= 1'b0;
            wtchdg_clr <= 1'b0;
        end else begin
            state <= state_nxt;
            if ((state_nxt != state) || !wtchdg_rst_n) begin
                timer <= '0;
            end else if (timer != '1) begin
                timer <= timer + 1'b1;
            end
            pll_rst    <= (state_nxt == S_PLL_RST);
            lane_rst   <= (state_nxt inside {S_PLL_RST, S_PLL_WAIT, S_LANE_RST});
            rx_rst     <= (state_nxt != S_DONE);
            seq_done   <= (state_nxt == S_DONE);
            // held off during a watchdog reset so its pulse is never cut short
            wtchdg_clr <= wtchdg_rst_n && (state_nxt != state);
        end
    end

    assign wtchdg_in = seq_done;

endmodule

// File: tb/tb_hsst_rst_seq_v1_0.sv
// Directed plus randomized bench for hsst_rst_seq_v1_0 against a phase-level reference model.
module tb_hsst_rst_seq_v1_0;

    localparam int PLLC = 64;
    localparam int LANEC = 32;
    localparam int RXC = 16;
    localparam int LSC = 128;

    logic clk = 1'b0;
    logic rst_n, pll_lock_async, cdr_lock_async, wtchdg_rst_n;
    logic pll_rst, lane_rst, rx_rst, seq_done, wtchdg_in, wtchdg_clr;
    logic [5:0] obs;

    int vectors = 0;
    int miscompares = 0;

    // reference model: phase 0..5 = pll_rst, pll_wait, lane_rst, cdr_wait, rx_rst, done
    int m_phase, m_cyc, p_cnt, c_cnt;
    bit p_s1, p_s2, c_s1, c_s2, m_clr;
    int dur [6] = '{PLLC, 0, LANEC, 0, RXC, 0};

    int n, pf, lf, df, clr_cnt;

    always #5 clk = ~clk;

    assign obs = {pll_rst, lane_rst, rx_rst, seq_done, wtchdg_in, wtchdg_clr};

    hsst_rst_seq_v1_0 dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pll_lock_async (pll_lock_async),
        .cdr_lock_async (cdr_lock_async),
        .wtchdg_rst_n   (wtchdg_rst_n),
        .pll_rst        (pll_rst),
        .lane_rst       (lane_rst),
        .rx_rst         (rx_rst),
        .seq_done       (seq_done),
        .wtchdg_in      (wtchdg_in),
        .wtchdg_clr     (wtchdg_clr)
    );

    task automatic model_reset();
        m_phase = 0; m_cyc = 1; m_clr = 0;
        p_s1 = 0; p_s2 = 0; c_s1 = 0; c_s2 = 0;
        p_cnt = 0; c_cnt = 0;
    endtask

    task automatic model_step();
        bit pl, cl;
        int np;
        pl = p_s2; cl = c_s2;
        np = m_phase;
        if (!wtchdg_rst_n) np = 0;
        else if (m_phase >= 2 && !pl) np = 0;
        else if (m_phase >= 4 && !cl) np = 3;
        else if (dur[m_phase] != 0) begin
            if (m_cyc == dur[m_phase]) np = m_phase + 1;
        end
        else if (m_phase == 1 && p_cnt == LSC) np = 2;
        else if (m_phase == 3 && c_cnt == LSC) np = 4;
        m_clr = (np != m_phase) && wtchdg_rst_n;
        m_cyc = ((np != m_phase) || !wtchdg_rst_n) ? 1 : m_cyc + 1;
        m_phase = np;
        p_cnt = pl ? ((p_cnt < LSC) ? p_cnt + 1 : LSC) : 0;
        c_cnt = cl ? ((c_cnt < LSC) ? c_cnt + 1 : LSC) : 0;
        p_s2 = p_s1; p_s1 = pll_lock_async;
        c_s2 = c_s1; c_s1 = cdr_lock_async;
    endtask

    function automatic logic [5:0] model_out();
        return {m_phase == 0, m_phase <= 2, m_phase <= 4, m_phase == 5, m_phase == 5, m_clr};
    endfunction

    task automatic check6(input string tag, input logic [5:0] o, input logic [5:0] e);
        vectors++;
        assert (o === e) else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b", tag, o, e);
        end
    endtask

    task automatic check_int(input string tag, input int o, input int e);
        vectors++;
        assert (o === e) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check6("cycle_outputs", obs, model_out());
    endtask

    task automatic run(input int k);
        for (int i = 0; i < k; i++) cycle();
    endtask

    task automatic run_until_done(input int bound);
        int k;
        k = 0;
        while (!seq_done && k < bound) begin
            cycle();
            k++;
        end
        check_int("reach_done", int'(seq_done), 1);
    endtask

    task automatic apply_reset(input logic pll_val);
        @(negedge clk);
        rst_n = 1'b0;
        pll_lock_async = pll_val;
        model_reset();
        @(negedge clk);
        check6("reset_values", obs, 6'b111000);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        pll_lock_async = 1'b1;
        cdr_lock_async = 1'b1;
        wtchdg_rst_n = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        check6("reset_values", obs, 6'b111000);
        rst_n = 1'b1;

        // clean bring-up with both locks high from time zero
        n = 0; pf = -1; lf = -1; df = -1; clr_cnt = 0;
        while (n < 1000 && df < 0) begin
            cycle();
            n++;
            if (pf < 0 && !pll_rst) pf = n;
            if (lf < 0 && !lane_rst) lf = n;
            if (seq_done) df = n;
            if (wtchdg_clr) clr_cnt++;
        end
        check_int("bringup_pll_rst_fall", pf, PLLC);
        check_int("bringup_lane_rst_fall", lf, 2 + LSC + 1 + LANEC);
        check_int("bringup_done", df, 2 + LSC + 1 + LANEC + 1 + RXC);
        check_int("bringup_clr_pulses", clr_cnt, 5);
        run(20);

        // PLL loss while done: seen after sync plus one state-register cycle
        pll_lock_async = 1'b0;
        run(2);
        check6("pll_loss_2cyc", obs, 6'b000110);
        cycle();
        check6("pll_loss_3cyc", obs, 6'b111001);
        run(10);
        pll_lock_async = 1'b1;
        run_until_done(2000);

        // CDR loss while done: back to CDR wait only
        cdr_lock_async = 1'b0;
        run(3);
        check6("cdr_loss", obs, 6'b001001);
        run(5);
        cdr_lock_async = 1'b1;
        run_until_done(2000);

        // watchdog restart with PLL lock held low
        pll_lock_async = 1'b0;
        wtchdg_rst_n = 1'b0;
        clr_cnt = 0;
        for (int i = 0; i < 512; i++) begin
            cycle();
            if (wtchdg_clr) clr_cnt++;
        end
        check_int("wd_pulse_clr", clr_cnt, 0);
        check6("wd_pulse_held", obs, 6'b111000);
        wtchdg_rst_n = 1'b1;
        n = 0; pf = -1;
        while (n < 200 && pf < 0) begin
            cycle();
            n++;
            if (!pll_rst) pf = n;
        end
        check_int("wd_pll_rst_fall", pf, PLLC);
        run(50);
        pll_lock_async = 1'b1;
        run_until_done(2000);

        // randomized disturbances from the done state and mid-sequence
        for (int ep = 0; ep < 12; ep++) begin
            for (int hit = 0; hit < 2; hit++) begin
                int kind, len;
                kind = $urandom_range(0, 3);
                len = $urandom_range(1, 40);
                run($urandom_range(0, 150));
                if (kind == 0 || kind == 3) pll_lock_async = 1'b0;
                if (kind == 1) cdr_lock_async = 1'b0;
                if (kind >= 2) wtchdg_rst_n = 1'b0;
                run(len);
                pll_lock_async = 1'b1;
                cdr_lock_async = 1'b1;
                wtchdg_rst_n = 1'b1;
            end
            run_until_done(3000);
        end

        // debounce restart: PLL lock drops for 10 cycles during PLL wait
        apply_reset(1'b1);
        run(100);
        pll_lock_async = 1'b0;
        run(10);
        pll_lock_async = 1'b1;
        n = 110; lf = -1;
        while (n < 1000 && lf < 0) begin
            cycle();
            n++;
            if (!lane_rst) lf = n;
        end
        check_int("debounce_lane_rst_fall", lf, 111 + 2 + LSC - 1 + 1 + LANEC);
        run_until_done(2000);

        // asynchronous reset in the middle of lane reset
        apply_reset(1'b1);
        run(2 + LSC + 1 + 10);
        check6("in_lane_rst", obs, 6'b011000);
        #2;
        rst_n = 1'b0;
        #1;
        check6("async_reset_no_edge", obs, 6'b111000);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        run_until_done(2000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
